// File: rtl/axis_uart_fifo_bridge.sv
// Full-duplex AXI-Stream <-> UART bridge: buffered TX serialiser, oversampling RX with error pulses.
// Define AXIS_UART_PARITY_EN to add an even-parity bit to every frame in both directions.
`timescale 1ns/1ps
module axis_uart_fifo_bridge #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_axis_data,
  input  logic                          s_axis_valid,
  input  logic                          s_axis_last,
  output logic                          s_axis_ready,
  output logic                          uart_tx,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          m_axis_data,
  output logic                          m_axis_valid,
  input  logic                          m_axis_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count,
  output logic                          tx_busy,
  output logic                          tx_last_done,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               push, pop, fifo_empty;

  assign s_axis_ready  = rst & (count < (AW+1)'(FIFO_DEPTH));
  assign push          = s_axis_valid & s_axis_ready;
  assign fifo_empty    = (count == '0);
  assign tx_fifo_count = count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_axis_last, s_axis_data};
  end

  // ---------------- TX FSM ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [BW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_last, tx_last_n, tx_par, tx_par_n;
  logic                 tx_q, tx_bit, tx_bit_end, tx_load;

  always_comb begin
    tx_state_n   = tx_state;
    tx_idx_n     = tx_idx;
    tx_shift_n   = tx_shift;
    tx_last_n    = tx_last;
    tx_par_n     = tx_par;
    tx_load      = 1'b0;
    tx_last_done = 1'b0;
    tx_bit_end   = (tx_cnt == CW'(CLKS_PER_BIT - 1));
    tx_cnt_n     = (tx_state == T_IDLE || tx_bit_end) ? '0 : tx_cnt + 1'b1;
    case (tx_state)
      T_IDLE:  tx_load = !fifo_empty;
      T_START: if (tx_bit_end) tx_state_n = T_DATA;
      T_DATA: if (tx_bit_end) begin
        tx_shift_n = tx_shift >> 1;
        if (tx_idx == BW'(DATA_BITS - 1)) begin
          tx_idx_n = '0;
`ifdef AXIS_UART_PARITY_EN
          tx_state_n = T_PAR;
`else
          tx_state_n = T_STOP;
`endif
        end else begin
          tx_idx_n = tx_idx + 1'b1;
        end
      end
      T_PAR:   if (tx_bit_end) tx_state_n = T_STOP;
      T_STOP: if (tx_bit_end) begin
        if (tx_idx == BW'(STOP_BITS - 1)) begin
          tx_last_done = tx_last;
          tx_idx_n     = '0;
          if (fifo_empty) tx_state_n = T_IDLE;
          else            tx_load    = 1'b1;
        end else begin
          tx_idx_n = tx_idx + 1'b1;
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
    // Back-to-back frames reload straight from STOP, so no idle gap is inserted.
    if (tx_load) begin
      tx_state_n              = T_START;
      tx_cnt_n                = '0;
      tx_idx_n                = '0;
      {tx_last_n, tx_shift_n} = mem[rd_ptr];
`ifdef AXIS_UART_PARITY_EN
      tx_par_n                = ^mem[rd_ptr][DATA_BITS-1:0];
`endif
    end
    pop = tx_load;
    case (tx_state_n)
      T_START: tx_bit = 1'b0;
      T_DATA:  tx_bit = tx_shift_n[0];
      T_PAR:   tx_bit = tx_par_n;
      default: tx_bit = 1'b1;
    endcase
  end

  // uart_tx is registered from the next-state decode so the line never glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_last  <= 1'b0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_last  <= tx_last_n;
      tx_par   <= tx_par_n;
      tx_q     <= tx_bit;
    end
  end

  assign uart_tx = tx_q;
  assign tx_busy = (tx_state != T_IDLE);

  // ---------------- RX ----------------
  rx_state_t            rx_state, rx_state_n;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [BW-1:0]        rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n, m_data_q;
  logic                 rx_par, rx_par_n, rx_done, rx_bit_end;
  logic                 frame_bad, par_bad, rx_good, rx_ovr, rx_load;
  logic                 m_valid_q, ferr_q, perr_q, ovr_q;

  assign rx_bit_end = (rx_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    rx_done    = 1'b0;
    case (rx_state)
      R_IDLE: begin
        rx_cnt_n = CW'(1);  // the detection cycle is tick 0 of the start bit
        if (rx_prev && !rx_s2) rx_state_n = R_START;
      end
      R_START: if (rx_cnt == CW'(CLKS_PER_BIT / 2)) begin
        rx_cnt_n   = '0;
        rx_idx_n   = '0;
        rx_state_n = rx_s2 ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_bit_end) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
        if (rx_idx == BW'(DATA_BITS - 1)) begin
`ifdef AXIS_UART_PARITY_EN
          rx_state_n = R_PAR;
`else
          rx_state_n = R_STOP;
`endif
        end else begin
          rx_idx_n = rx_idx + 1'b1;
        end
      end
      R_PAR: if (rx_bit_end) begin
        rx_cnt_n   = '0;
        rx_par_n   = rx_s2;
        rx_state_n = R_STOP;
      end
      R_STOP: if (rx_bit_end) begin
        rx_cnt_n   = '0;
        rx_done    = 1'b1;
        rx_state_n = R_IDLE;
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  assign frame_bad = rx_done & ~rx_s2;
`ifdef AXIS_UART_PARITY_EN
  assign par_bad   = rx_done & rx_s2 & ((^rx_shift) ^ rx_par);
`else
  assign par_bad   = 1'b0;
`endif
  assign rx_good   = rx_done & rx_s2 & ~par_bad;
  assign rx_ovr    = rx_good & m_valid_q & ~m_axis_ready;
  assign rx_load   = rx_good & ~(m_valid_q & ~m_axis_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= R_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_par    <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_s1     <= uart_rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_idx    <= rx_idx_n;
      rx_shift  <= rx_shift_n;
      rx_par    <= rx_par_n;
      if (rx_load) m_data_q <= rx_shift;
      m_valid_q <= rx_load | (m_valid_q & ~m_axis_ready);
      ferr_q    <= frame_bad;
      perr_q    <= par_bad;
      ovr_q     <= rx_ovr;
    end
  end

  assign m_axis_data   = m_data_q;
  assign m_axis_valid  = m_valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_parity_err = perr_q;
  assign rx_overrun    = ovr_q;
endmodule

// File: tb/tb_axis_uart_fifo_bridge.sv
// Directed/randomized bench for axis_uart_fifo_bridge; expected line waveforms come from a frame-bit model.
`timescale 1ns/1ps
module tb_axis_uart_fifo_bridge;
  localparam int DB  = 8;
  localparam int CPB = 16;
  localparam int FD  = 4;
  localparam int SB  = 1;
`ifdef AXIS_UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS  = 1 + DB + P + SB;
  localparam int FRAME  = NBITS * CPB;
  localparam int RX_LAT = 1 + 2 + ((2 * (DB + P) + 3) * CPB) / 2 + 1;

  logic clk = 1'b0, rst = 1'b0;
  logic [DB-1:0] s_axis_data = '0, m_axis_data;
  logic s_axis_valid = 1'b0, s_axis_last = 1'b0, s_axis_ready;
  logic uart_tx, uart_rx, m_axis_valid, m_axis_ready = 1'b1;
  logic [$clog2(FD):0] tx_fifo_count;
  logic tx_busy, tx_last_done, rx_frame_err, rx_parity_err, rx_overrun;
  logic loop_en = 1'b0, rx_drv = 1'b1;

  assign uart_rx = loop_en ? uart_tx : rx_drv;
  always #5 clk = ~clk;

  axis_uart_fifo_bridge #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_last(s_axis_last),
    .s_axis_ready(s_axis_ready), .uart_tx(uart_tx), .uart_rx(uart_rx),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .tx_fifo_count(tx_fifo_count), .tx_busy(tx_busy), .tx_last_done(tx_last_done),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
  );

  int n_total = 0, n_pass = 0, n_fail = 0;
  int n_last = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, n_vcyc = 0;
  logic [DB-1:0] rx_got[$];

  always @(negedge clk) begin
    if (tx_last_done)  n_last++;
    if (rx_frame_err)  n_ferr++;
    if (rx_parity_err) n_perr++;
    if (rx_overrun)    n_ovr++;
    if (m_axis_valid)  n_vcyc++;
    if (m_axis_valid && m_axis_ready) rx_got.push_back(m_axis_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit b of a UART frame carrying w: start, data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [DB-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= DB) return w[b-1];
    if (P == 1 && b == DB + 1) return ^w;
    return 1'b1;
  endfunction

  logic [DB-1:0] wq[$], sent[$];
  logic          lq[$];
  int wave_err, busy_cyc, acc_full, cnt_full, j_last, j_vrise, j_ovr, n_acc;

  // Streams wq/lq into the TX port with valid held high; j counts cycles from the first accept edge.
  task automatic run_tx(input int ncyc);
    logic [DB-1:0] words[$];
    logic acc, prev_v, e;
    int f;
    words = wq; sent = wq;
    wave_err = 0; busy_cyc = 0; acc_full = -1; cnt_full = -1;
    j_last = -1; j_vrise = -1; j_ovr = -1; n_acc = 0;
    s_axis_valid = (wq.size() != 0);
    if (s_axis_valid) begin s_axis_data = wq[0]; s_axis_last = lq[0]; end
    prev_v = m_axis_valid;
    for (int j = 0; j < ncyc; j++) begin
      acc = s_axis_valid && s_axis_ready;
      @(posedge clk); #1;
      if (acc) begin
        void'(wq.pop_front()); void'(lq.pop_front()); n_acc++;
        s_axis_valid = (wq.size() != 0);
        if (s_axis_valid) begin s_axis_data = wq[0]; s_axis_last = lq[0]; end
        else begin s_axis_data = '0; s_axis_last = 1'b0; end
      end
      @(negedge clk);
      if (j == 0) e = 1'b1;
      else begin
        f = (j - 1) / FRAME;
        e = (f < words.size()) ? frame_bit(words[f], ((j - 1) % FRAME) / CPB) : 1'b1;
      end
      if (uart_tx !== e) wave_err++;
      if (tx_busy) busy_cyc++;
      if (s_axis_valid && !s_axis_ready && acc_full < 0) begin
        acc_full = n_acc; cnt_full = int'(tx_fifo_count);
      end
      if (tx_last_done && j_last < 0) j_last = j;
      if (rx_overrun && j_ovr < 0) j_ovr = j;
      if (m_axis_valid && !prev_v && j_vrise < 0) j_vrise = j;
      prev_v = m_axis_valid;
    end
  endtask

  task automatic drive_frame(input logic [DB-1:0] w, input logic stop_val);
    for (int b = 0; b < NBITS; b++) begin
      rx_drv = (b == 1 + DB + P) ? stop_val : frame_bit(w, b);
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int b_last, b_ferr, b_ovr, b_vcyc, b_rx, tags, low_cyc, busy2;
    logic [DB-1:0] w;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 1);
    check("rst_s_ready", 32'(s_axis_ready), 0);
    check("rst_m_valid", 32'(m_axis_valid), 0);
    check("rst_m_data", 32'(m_axis_data), 0);
    check("rst_count", 32'(tx_fifo_count), 0);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_pulses", 32'({tx_last_done, rx_frame_err, rx_parity_err, rx_overrun}), 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single 0xA5 frame, line waveform
    b_last = n_last;
    wq = '{8'hA5}; lq = '{1'b0};
    run_tx(FRAME + 40);
    check("a5_wave", wave_err, 0);
    check("a5_busy", busy_cyc, FRAME);
    check("a5_no_last", n_last - b_last, 0);

    // Loopback 0x3C tagged last
    loop_en = 1'b1;
    b_last = n_last; b_rx = rx_got.size();
    wq = '{8'h3C}; lq = '{1'b1};
    run_tx(FRAME + 40);
    check("3c_wave", wave_err, 0);
    check("3c_last_cnt", n_last - b_last, 1);
    check("3c_last_at", j_last, FRAME);
    check("3c_rx_lat", j_vrise, RX_LAT);
    check("3c_rx_cnt", rx_got.size() - b_rx, 1);
    if (rx_got.size() > b_rx) check("3c_rx_data", 32'(rx_got[b_rx]), 32'h3C);

    // Random 6-word burst with valid held high, loopback
    b_last = n_last; b_rx = rx_got.size(); tags = 0;
    for (int i = 0; i < 6; i++) begin
      wq.push_back(8'($urandom));
      lq.push_back(1'($urandom));
      if (lq[i]) tags++;
    end
    run_tx(6 * FRAME + 40);
    check("burst_wave", wave_err, 0);
    check("burst_busy", busy_cyc, 6 * FRAME);
    check("burst_full_acc", acc_full, 5);
    check("burst_full_cnt", cnt_full, FD);
    check("burst_acc", n_acc, 6);
    check("burst_last_cnt", n_last - b_last, tags);
    check("burst_rx_cnt", rx_got.size() - b_rx, 6);
    for (int i = 0; i < 6; i++)
      if (rx_got.size() > b_rx + i) check("burst_rx_data", 32'(rx_got[b_rx + i]), 32'(sent[i]));

    // Overrun: hold m_axis_ready low across two frames
    m_axis_ready = 1'b0;
    b_ovr = n_ovr; b_rx = rx_got.size();
    wq = '{8'h11, 8'h22}; lq = '{1'b0, 1'b0};
    run_tx(2 * FRAME + 40);
    check("ovr_valid", 32'(m_axis_valid), 1);
    check("ovr_data", 32'(m_axis_data), 32'h11);
    check("ovr_cnt", n_ovr - b_ovr, 1);
    check("ovr_at", j_ovr, RX_LAT + FRAME);
    @(posedge clk); #1 m_axis_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ovr_drain_valid", 32'(m_axis_valid), 0);
    check("ovr_drain_cnt", rx_got.size() - b_rx, 1);
    if (rx_got.size() > b_rx) check("ovr_drain_data", 32'(rx_got[b_rx]), 32'h11);

    // Short low glitch on uart_rx
    loop_en = 1'b0;
    @(posedge clk); #1;
    b_vcyc = n_vcyc; b_ferr = n_ferr;
    rx_drv = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx_drv = 1'b1;
    repeat (40) @(posedge clk); #1;
    check("glitch_valid", n_vcyc - b_vcyc, 0);
    check("glitch_err", (n_ferr - b_ferr) + n_perr + (n_ovr - b_ovr - 1), 0);

    // Frame with stop forced low, then a good externally driven frame
    w = 8'($urandom);
    drive_frame(w, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("ferr_cnt", n_ferr - b_ferr, 1);
    check("ferr_valid", n_vcyc - b_vcyc, 0);
    b_rx = rx_got.size();
    w = 8'($urandom);
    drive_frame(w, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("ext_rx_cnt", rx_got.size() - b_rx, 1);
    if (rx_got.size() > b_rx) check("ext_rx_data", 32'(rx_got[b_rx]), 32'(w));
    check("ext_ferr_cnt", n_ferr - b_ferr, 1);

    // Reset mid-DATA with three words queued
    for (int i = 0; i < 4; i++) begin wq.push_back(8'($urandom)); lq.push_back(1'b0); end
    run_tx(60);
    check("mid_wave", wave_err, 0);
    check("mid_count", 32'(tx_fifo_count), 3);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_uart_tx", 32'(uart_tx), 1);
    check("abort_count", 32'(tx_fifo_count), 0);
    check("abort_busy", 32'(tx_busy), 0);
    low_cyc = 0; busy2 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (!uart_tx) low_cyc++;
      if (tx_busy) busy2++;
    end
    check("abort_quiet_line", low_cyc, 0);
    check("abort_quiet_busy", busy2, 0);
    check("parity_err_none", n_perr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/axis_uart_fifo_bridge.md
# axis_uart_fifo_bridge

Full-duplex AXI-Stream ⇄ UART bridge.
- TX path: a parametrised TX FIFO accepts AXI-Stream words and serialises them as UART frames.
- RX path: an oversampling receiver returns UART frames as a backpressured AXI-Stream master.
- Next-generation replacement for the fixed 8-bit, unbuffered bridge at the top of the TinyTapeout wrapper. Adds a configurable baud divisor, stop-bit count, TX buffering, RX error reporting and optional parity.

## Interface
Parameters:
- DATA_BITS, 8, payload bits per frame (5..9)
- CLKS_PER_BIT, 16, clk cycles per UART bit (≥4, even)
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, ≥2)
- STOP_BITS, 1, stop bits sent (1 or 2); RX checks only the first

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset: synchronous and active-low
- s_axis_data  in  DATA_BITS  TX word
- s_axis_valid  in  1  TX word valid
- s_axis_last  in  1  end-of-packet tag, stored with the word
- s_axis_ready  out  1  FIFO can accept
- uart_tx  out  1  serial out, idle high
- uart_rx  in  1  serial in, asynchronous
- m_axis_data  out  DATA_BITS  received word
- m_axis_valid  out  1  received word valid
- m_axis_ready  in  1  downstream accepts
- tx_fifo_count  out  $clog2(FIFO_DEPTH)+1  stored TX words
- tx_busy  out  1  TX FSM not IDLE
- tx_last_done  out  1  1-cycle pulse: stop period of a last-tagged word ended
- rx_frame_err  out  1  1-cycle pulse: stop bit sampled low
- rx_parity_err  out  1  1-cycle pulse: parity mismatch
- rx_overrun  out  1  1-cycle pulse: word completed while m_axis_valid&!m_axis_ready

## Operation
- Reset (rst low at a clk edge) forces the following:
  - uart_tx=1, s_axis_ready=0, m_axis_valid=0, m_axis_data=0
  - tx_fifo_count=0, tx_busy=0, all pulses 0
  - FIFO emptied, both FSMs to IDLE
- Reset mid-frame aborts that frame; the truncated frame stays on the line and is not resent.
- s_axis_ready = rst & (tx_fifo_count < FIFO_DEPTH). No pass-through when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop leaves the count unchanged.
- TX FSM states: IDLE → START → DATA → [PARITY] → STOP.
  - IDLE with FIFO non-empty: pop, load shifter and last tag, go to START.
  - DATA sends DATA_BITS bits, LSB first.
  - STOP lasts STOP_BITS bit periods.
  - At the end of STOP: go to START if the FIFO is non-empty (pop in that cycle, no idle gap); otherwise go to IDLE.
  - tx_last_done pulses in the final STOP cycle when the tag is 1.
- RX datapath: 2-flop synchroniser on uart_rx. The FSM runs on the synchronised value.
- RX FSM states: IDLE → START → DATA → [PARITY] → STOP.
  - IDLE: a high→low transition enters START.
  - START: sample at CLKS_PER_BIT/2. If high (glitch), return to IDLE silently.
  - DATA, PARITY and STOP bits are each sampled CLKS_PER_BIT cycles after the previous sample.
  - STOP sampled low: pulse rx_frame_err, discard the word.
  - Parity bad: pulse rx_parity_err, discard the word. This takes priority over overrun.
  - Good word with output register free, or freed the same cycle (m_axis_ready=1): load m_axis_data and set m_axis_valid.
  - Good word while m_axis_valid & !m_axis_ready: drop the new word, pulse rx_overrun; held data is unchanged.
  - After the STOP sample, return to IDLE. The next start edge may be detected in the following cycle.
- Output handshake: m_axis_valid stays high with m_axis_data stable until m_axis_ready=1. It clears on the transfer cycle.

## Timing
- A word accepted at edge k into an empty, idle TX path: uart_tx goes low after edge k+1.
- Every bit period, including start, parity and stop, is exactly CLKS_PER_BIT cycles.
- Frame length is (1+DATA_BITS+P+STOP_BITS)·CLKS_PER_BIT cycles, with P=1 when parity is compiled in.
- RX latency: m_axis_valid rises one cycle after the STOP sample cycle. That sample is 2 synchroniser cycles plus (DATA_BITS+P+1.5)·CLKS_PER_BIT cycles after the start edge reaches uart_rx.
- Error pulses coincide with the cycle m_axis_valid would have risen.

## Configuration
- AXIS_UART_PARITY_EN defined:
  - TX inserts an even-parity bit (XOR of data bits) after DATA.
  - RX samples and checks it.
- AXIS_UART_PARITY_EN undefined:
  - No PARITY state, P=0.
  - rx_parity_err tied 0.

## Test plan
All scenarios use DATA_BITS=8, CLKS_PER_BIT=16, FIFO_DEPTH=4, STOP_BITS=1, parity off unless stated.
- Push 0xA5 once → uart_tx: 16 cycles low, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 16 high. Total 160 cycles. With AXIS_UART_PARITY_EN: a 0 parity bit is added, total 176 cycles.
- Push 6 words with s_axis_valid held high → first word popped immediately. Ready drops after the 5th acceptance with tx_fifo_count=4. All six frames go out contiguously with no idle cycle; tx_busy stays high for 960 cycles.
- Loop uart_tx to uart_rx and send 0x3C with last=1 → tx_last_done pulses once. m_axis_valid rises with m_axis_data=0x3C.
- Hold m_axis_ready=0 and receive 0x11 then 0x22 → m_axis_data stays 0x11. rx_overrun pulses once, at the end of the 0x22 frame.
- Drive uart_rx low for 4 cycles → no valid, no error pulse. Send a frame with the stop bit forced low → rx_frame_err pulses, m_axis_valid stays 0.
- Assert rst for 1 cycle mid-DATA of a frame with 3 words queued → uart_tx=1 next cycle, tx_fifo_count=0. No further frames are sent.
